// File: rtl/stack_arb_pkg.sv
// Shared types and constants for the two-client stack arbiter.
package stack_arb_pkg;

  // Arbiter sequencing: wait for a request, strobe the stack, hand back the response.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

  // One-hot client mask from a client index.
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/stack_arbiter_rr_arb2.sv
// Two-way round-robin picker: the client at the pointer wins if eligible,
// otherwise the other eligible client is chosen.
module rr_arb2 (
  input  logic [1:0] elig,
  input  logic       ptr,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  // Pure combinational pick; the caller owns the pointer register.
  always_comb begin
    gnt_valid = |elig;
    gnt_idx   = ptr;
    if (!elig[ptr]) begin
      gnt_idx = ~ptr;
    end
  end

endmodule

// File: rtl/stack_arbiter.sv
// Shares one LIFO stack between two valid/ready clients with round-robin
// arbitration, one operation in flight at a time.
// Optional feature macro: STACK_ARB_ERR_EN -- when defined, push-on-full and
// pop-on-empty are accepted and answered with rsp_err instead of waiting.
module stack_arbiter
  import stack_arb_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 5
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [1:0]         req_valid,
  input  logic [1:0]         req_op,
  input  logic [2*WIDTH-1:0] req_data,
  output logic [1:0]         req_ready,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               rsp_err,
  output logic               stk_push,
  output logic               stk_pop,
  output logic [WIDTH-1:0]   stk_din,
  input  logic [WIDTH-1:0]   stk_dout,
  input  logic               stk_empty,
  input  logic               stk_full
);

  // DEPTH only documents the attached stack; reject nonsense values early.
  if (DEPTH < 1) begin : g_depth_chk
    $error("stack_arbiter: DEPTH must be at least 1");
  end

  state_e           state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             op_q, op_d;
  logic             ptr_q, ptr_d;
  logic             err_q, err_d;
  logic             first_q, first_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic [WIDTH-1:0] hold_q, hold_d;

  logic [1:0]       elig;
  logic             gnt_valid;
  logic             gnt_idx;
  logic             win_op;
  logic [WIDTH-1:0] win_data;
  logic             bad;

  // Which clients may be granted this cycle.
  always_comb begin
    elig = '0;
    for (int i = 0; i < 2; i++) begin
`ifdef STACK_ARB_ERR_EN
      elig[i] = req_valid[i];
`else
      elig[i] = req_valid[i] && ((req_op[i] == OP_PUSH) ? !stk_full : !stk_empty);
`endif
    end
  end

  rr_arb2 u_rr (
    .elig      (elig),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Operation and data of the winning client, plus whether it would misuse the stack.
  always_comb begin
    win_op   = req_op[gnt_idx];
    win_data = gnt_idx ? req_data[2*WIDTH-1:WIDTH] : req_data[WIDTH-1:0];
`ifdef STACK_ARB_ERR_EN
    bad      = (win_op == OP_PUSH) ? stk_full : stk_empty;
`else
    bad      = 1'b0;
`endif
  end

  // Next-state logic and the combinational accept strobe.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    op_d      = op_q;
    ptr_d     = ptr_q;
    err_d     = err_q;
    din_d     = din_q;
    hold_d    = hold_q;
    first_d   = (state_q != RESP);
    req_ready = 2'b00;
    case (state_q)
      IDLE: begin
        if (gnt_valid && rstn) begin
          req_ready = onehot2(gnt_idx);
          gnt_d     = gnt_idx;
          op_d      = win_op;
          ptr_d     = ~gnt_idx;
          err_d     = bad;
          if (win_op == OP_PUSH) begin
            din_d = win_data;
          end
          state_d = bad ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        state_d = RESP;
      end
      RESP: begin
        if (first_q) begin
          hold_d = stk_dout;
        end
        if (rsp_ready[gnt_q]) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      op_q    <= OP_POP;
      ptr_q   <= 1'b0;
      err_q   <= 1'b0;
      first_q <= 1'b0;
      din_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      first_q <= first_d;
      din_q   <= din_d;
      hold_q  <= hold_d;
    end
  end

  // Outputs decoded from the registered state. The stack updates dout on the
  // RESP entry edge, so the first RESP cycle forwards it and later cycles use
  // the held copy.
  always_comb begin
    stk_push  = (state_q == ISSUE) && (op_q == OP_PUSH);
    stk_pop   = (state_q == ISSUE) && (op_q == OP_POP);
    stk_din   = din_q;
    rsp_valid = (state_q == RESP) ? onehot2(gnt_q) : 2'b00;
    rsp_data  = '0;
    if ((state_q == RESP) && (op_q == OP_POP) && !err_q) begin
      rsp_data = first_q ? stk_dout : hold_q;
    end
`ifdef STACK_ARB_ERR_EN
    rsp_err   = (state_q == RESP) && err_q;
`else
    rsp_err   = 1'b0;
`endif
  end

endmodule
